karp_out_port_buffer: RTL and testbench

- Output-port stage directly downstream of Karpentium_Processor_III.
- Captures 16-bit words driven on the processor's `out` port into a small FIFO.
- Presents the words to an external consumer over a valid/ready handshake, so slow peripherals never miss a processor OUT.
- Reports fill level and a sticky overflow flag.

---
 rtl/karp_out_port_buffer_if.sv | 28 ++
 rtl/karp_out_port_buffer.sv | 105 ++++++++++
 tb/tb_karp_out_port_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/karp_out_port_buffer_if.sv
`default_nettype none
// karp_out_port_buffer_if: processor-side capture bus plus consumer-side valid/ready bus.
// slave is the buffer's view; master is the surrounding system's view.
interface karp_out_port_buffer_if #(
  parameter int ADDR_W = 3
);
  logic [15:0]     out_word;
  logic            out_strobe;
  logic [15:0]     dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [ADDR_W:0] count;
  logic            full;
  logic            empty;
  logic            overflow;
  logic            ovf_clr;

  modport slave (
    input  out_word, out_strobe, dout_ready, ovf_clr,
    output dout, dout_valid, count, full, empty, overflow
  );

  modport master (
    output out_word, out_strobe, dout_ready, ovf_clr,
    input  dout, dout_valid, count, full, empty, overflow
  );
endinterface
`default_nettype wire

// File: rtl/karp_out_port_buffer.sv
`default_nettype none
// karp_out_port_buffer: FIFO between the Karpentium III `out` port and a valid/ready consumer.
// Optional KARP_OUT_CHANGE_DETECT_EN also captures whenever out_word differs from the last accepted word.
module karp_out_port_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  karp_out_port_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic w_empty;
  logic w_full;
  logic w_capture;
  logic w_push;
  logic w_pop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == C_FULL_CNT);
  assign w_pop   = !w_empty && bus.dout_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push  = w_capture && (!w_full || w_pop);

`ifdef KARP_OUT_CHANGE_DETECT_EN
  logic [15:0] last_word_q;

  assign w_capture = bus.out_strobe || (bus.out_word != last_word_q);

  // Only accepted words update the reference, so a dropped change retriggers later.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      last_word_q <= '0;
    end else if (w_push) begin
      last_word_q <= bus.out_word;
    end
  end
`else
  assign w_capture = bus.out_strobe;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end else if (w_capture && !w_push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately unreset; it is masked by empty until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.out_word;
    end
  end

  assign bus.dout       = w_empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign bus.dout_valid = !w_empty;
  assign bus.count      = count_q;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_karp_out_port_buffer.sv
`default_nettype none
// tb_karp_out_port_buffer: randomized and directed stimulus scored against a queue-based model.
module tb_karp_out_port_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic clr;

  karp_out_port_buffer_if #(.ADDR_W(ADDR_W)) bus_if ();

  karp_out_port_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus_if)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  bit          ovf_m;
  logic [15:0] last_m;
  int          n;
  bit          pop_m, cap_m, push_m;
  logic [15:0] cur_w;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: the FIFO is a plain queue; outputs are checked at the falling edge,
  // then the queue advances by whatever the next rising edge will do.
  always @(negedge clk or negedge clr) begin
    if (!clr) begin
      #1;
      exp_q.delete();
      ovf_m  = 1'b0;
      last_m = 16'h0000;
      check("rst_count", 32'(bus_if.count), 32'd0);
      check("rst_valid", 32'(bus_if.dout_valid), 32'd0);
      check("rst_empty", 32'(bus_if.empty), 32'd1);
      check("rst_dout", 32'(bus_if.dout), 32'd0);
    end else begin
      n = exp_q.size();
      check("dout_valid", 32'(bus_if.dout_valid), 32'(n != 0));
      check("dout", 32'(bus_if.dout), (n != 0) ? 32'(exp_q[0]) : 32'd0);
      check("count", 32'(bus_if.count), 32'(n));
      check("full", 32'(bus_if.full), 32'(n == DEPTH));
      check("empty", 32'(bus_if.empty), 32'(n == 0));
      check("overflow", 32'(bus_if.overflow), 32'(ovf_m));

      pop_m = (n != 0) && (bus_if.dout_ready === 1'b1);
`ifdef KARP_OUT_CHANGE_DETECT_EN
      cap_m = bus_if.out_strobe || (bus_if.out_word != last_m);
`else
      cap_m = bus_if.out_strobe;
`endif
      push_m = cap_m && ((n < DEPTH) || pop_m);
      if (bus_if.ovf_clr) ovf_m = 1'b0;
      else if (cap_m && !push_m) ovf_m = 1'b1;
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) begin
        exp_q.push_back(bus_if.out_word);
        last_m = bus_if.out_word;
      end
    end
  end

  task automatic step(input bit s, input logic [15:0] w, input bit r, input bit oc);
    bus_if.out_strobe = s;
    bus_if.out_word   = w;
    bus_if.dout_ready = r;
    bus_if.ovf_clr    = oc;
    cur_w             = w;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int cycles, input bit r);
    for (int i = 0; i < cycles; i++) step(1'b0, cur_w, r, 1'b0);
  endtask

  initial begin
    bus_if.out_strobe = 1'b0;
    bus_if.out_word   = 16'h0000;
    bus_if.dout_ready = 1'b0;
    bus_if.ovf_clr    = 1'b0;
    cur_w             = 16'h0000;
    clr = 1'b1;
    #1 clr = 1'b0;
    #25 clr = 1'b1;
    @(posedge clk);
    #2;

    idle(2, 1'b0);

    // single word
    step(1'b1, 16'h00A5, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // fill, overflow, drain, wrap
    for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0009, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(8, 1'b1);
    step(1'b0, cur_w, 1'b0, 1'b1);
    for (int i = 10; i <= 12; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    idle(4, 1'b1);

    // push and pop together at full
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    idle(9, 1'b1);

    // ovf_clr wins over a same-cycle drop
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    idle(1, 1'b0);
    idle(8, 1'b1);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    clr = 1'b0;
    #10 clr = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    idle(3, 1'b1);

`ifdef KARP_OUT_CHANGE_DETECT_EN
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0020, 1'b0, 1'b0);
    idle(4, 1'b1);
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [15:0] w;
      w = cur_w;
`ifdef KARP_OUT_CHANGE_DETECT_EN
      if ($urandom_range(0, 3) == 0) w = 16'($urandom);
`else
      w = 16'($urandom);
`endif
      step(1'($urandom_range(0, 1)), w, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(DEPTH + 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
